// File: rtl/lsu_dmem_if.sv
// Request/response bundle between the execute stage and the load/store unit.
// master = core side (issues requests), slave = lsu_dmem.
interface lsu_dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req_valid, req_write, funct3, addr, wdata,
      input  req_ready, rsp_valid, rdata, err
   );

   modport slave (
      input  req_valid, req_write, funct3, addr, wdata,
      output req_ready, rsp_valid, rdata, err
   );
endinterface

// File: rtl/lsu_dmem.sv
// RV32I load/store unit with a private byte-lane data RAM.
// Optional macro LSU_RANGE_CHECK_EN: when defined, any address bit above
// ADDR_WIDTH-1 flags an error; otherwise upper bits are ignored and the RAM aliases.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; stores and errors resolve at accept
// S_LOAD | RAM word captured, sub-word select/extend into rdata
// S_RESP | one-cycle rsp_valid pulse, then back to idle
module lsu_dmem #(
   parameter int ADDR_WIDTH       = 12,
   parameter int RESET_CLEARS_MEM = 0
) (
   input  logic       clk,
   input  logic       rst,
   lsu_dmem_if.slave  bus
);
   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESP} state_t;

   logic [31:0]           mem_q [WORDS];
   logic [31:0]           rd_word_q;
   state_t                state_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  err_q;
   logic [31:0]           rdata_q;
   logic [1:0]            lane_q;
   logic [2:0]            f3_q;

   logic                  accept;
   logic                  f3_legal;
   logic                  misalign;
   logic                  range_err;
   logic                  req_err;
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [3:0]            be;
   logic [31:0]           wlanes;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_fmt;

   // req_ready_q is only high in S_IDLE, so accept implies the idle state
   assign accept   = bus.req_valid && req_ready_q;
   assign word_idx = bus.addr[ADDR_WIDTH-1:2];

`ifdef LSU_RANGE_CHECK_EN
   assign range_err = |bus.addr[31:ADDR_WIDTH];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH];
   assign range_err      = 1'b0;
`endif

   // Request decode: legality, alignment and store lane placement
   always_comb begin
      f3_legal = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = !bus.req_write;
         default:                f3_legal = 1'b0;
      endcase
      misalign = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
      req_err  = !f3_legal || misalign || range_err;
      case (bus.funct3[1:0])
         2'b00: begin
            be     = 4'b0001 << bus.addr[1:0];
            wlanes = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            be     = bus.addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{bus.wdata[15:0]}};
         end
         default: begin
            be     = 4'b1111;
            wlanes = bus.wdata;
         end
      endcase
   end

   // Data RAM: byte-lane writes and synchronous word read at accept
   always_ff @(posedge clk) begin
      if (rst) begin
         if (RESET_CLEARS_MEM != 0) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
         end
      end else if (accept && !req_err) begin
         if (bus.req_write) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem_q[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
         end else begin
            rd_word_q <= mem_q[word_idx];
         end
      end
   end

   // Load formatting from the captured word and latched lane/width
   always_comb begin
      ld_byte = rd_word_q[8*lane_q +: 8];
      ld_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
      case (f3_q)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_fmt = {24'h0, ld_byte};
         3'b101:  ld_fmt = {16'h0, ld_half};
         default: ld_fmt = rd_word_q;
      endcase
   end

   // Control FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         lane_q      <= '0;
         f3_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  lane_q      <= bus.addr[1:0];
                  f3_q        <= bus.funct3;
                  req_ready_q <= 1'b0;
                  if (req_err || bus.req_write) begin
                     err_q       <= req_err;
                     rdata_q     <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     state_q     <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               rdata_q     <= ld_fmt;
               err_q       <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: directed scenarios followed by random
// traffic checked against a byte-array memory model.
module tb_lsu_dmem;
   localparam int AW = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_dmem_if bus ();

   lsu_dmem #(.ADDR_WIDTH(AW), .RESET_CLEARS_MEM(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] ref_mem [2**AW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   // Reference: RV32I access semantics on a flat byte array
   function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic e,
                                 output logic [31:0] rd, output int lat);
      int size;
      logic legal;
      logic [31:0] off;
      logic [31:0] v;
      legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
              && !(wr && f3[2]);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      e = !legal || ((a % size) != 0);
`ifdef LSU_RANGE_CHECK_EN
      if ((a >> AW) != 0) e = 1'b1;
`endif
      rd  = 32'h0;
      lat = 1;
      if (e) return;
      off = a % (2**AW);
      if (wr) begin
         for (int i = 0; i < size; i++) ref_mem[off + i] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_mem[off + i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd  = v;
         lat = 2;
      end
   endfunction

   task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
      logic e_exp;
      logic [31:0] rd_exp;
      int lat_exp;
      int w;
      int lat;
      model(wr, f3, a, wd, e_exp, rd_exp, lat_exp);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.wdata     = wd;
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ":accept_in_time"}, 32'(w < 10), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.funct3    = 3'($urandom);
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 6) begin
         chk({tag, ":ready_low_busy"}, 32'(bus.req_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, ":latency"}, lat, lat_exp);
      chk({tag, ":err"}, 32'(bus.err), 32'(e_exp));
      chk({tag, ":rdata"}, bus.rdata, rd_exp);
      chk({tag, ":ready_low_resp"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, ":rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, ":ready_back"}, 32'(bus.req_ready), 32'd1);
      chk({tag, ":rdata_hold"}, bus.rdata, rd_exp);
   endtask

   initial begin
      logic e1, e2;
      logic [31:0] r1, r2;
      int l1, l2;
      logic [31:0] ra;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.funct3    = 3'd0;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset:req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset:rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset:rdata", bus.rdata, 32'h0);
      chk("reset:err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 2**(AW-2); i++) do_op(1'b1, 3'd2, 32'(i*4), $urandom, "init_sw");

      do_op(1'b1, 3'd2, 32'h10, 32'h8081_7F01, "sw_10");
      do_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
      do_op(1'b0, 3'd0, 32'h10, 32'h0, "lb_10");
      do_op(1'b0, 3'd0, 32'h11, 32'h0, "lb_11");
      do_op(1'b0, 3'd0, 32'h12, 32'h0, "lb_12");
      do_op(1'b0, 3'd4, 32'h12, 32'h0, "lbu_12");
      do_op(1'b0, 3'd1, 32'h12, 32'h0, "lh_12");
      do_op(1'b0, 3'd5, 32'h12, 32'h0, "lhu_12");
      do_op(1'b1, 3'd0, 32'h13, 32'hAA, "sb_13");
      do_op(1'b1, 3'd1, 32'h10, 32'h1234, "sh_10");
      do_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_merge");
      chk("lw_merge:spec_value", {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]},
          32'hAA81_1234);
      do_op(1'b0, 3'd2, 32'h12, 32'h0, "lw_misalign");
      do_op(1'b1, 3'd1, 32'h11, 32'hFFFF, "sh_misalign");
      do_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_bad_sh");
      do_op(1'b0, 3'd3, 32'h10, 32'h0, "f3_011");
      do_op(1'b1, 3'd4, 32'h10, 32'h0, "store_1xx");
      do_op(1'b0, 3'd2, 32'h0000_1000, 32'h0, "lw_1000");

      // Held request with addr changed mid-access, then immediate re-accept
      model(1'b0, 3'd2, 32'h10, 32'h0, e1, r1, l1);
      model(1'b0, 3'd1, 32'h22, 32'h0, e2, r2, l2);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.funct3    = 3'd2;
      bus.addr      = 32'h10;
      chk("hold:ready_idle", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.funct3 = 3'd1;
      bus.addr   = 32'h22;
      chk("hold:ready_load", 32'(bus.req_ready), 32'd0);
      chk("hold:no_rsp_load", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("hold:rsp1_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold:rsp1_rdata", bus.rdata, r1);
      chk("hold:ready_resp", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("hold:ready_after_resp", 32'(bus.req_ready), 32'd1);
      chk("hold:rsp_dropped", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("hold:second_accepted", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("hold:rsp2_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold:rsp2_rdata", bus.rdata, r2);
      chk("hold:rsp2_err", 32'(bus.err), 32'(e2));
      @(posedge clk);
      #1;

      // Reset while a load is in flight
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.funct3    = 3'd2;
      bus.addr      = 32'h10;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("rst_load:in_load", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_load:ready", 32'(bus.req_ready), 32'd1);
      chk("rst_load:no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("rst_load:rdata_clr", bus.rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_load:quiet", 32'(bus.rsp_valid), 32'd0);
      end

      // Store presented while reset is high must not land
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.funct3    = 3'd2;
      bus.addr      = 32'h10;
      bus.wdata     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_after_rst_sw");

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) ra = $urandom;
         else ra = 32'($urandom_range(0, 2**AW - 1));
         do_op(1'($urandom), 3'($urandom_range(0, 7)), ra, $urandom, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit plus data RAM, directly downstream of the execute-stage ALU.
- Takes the ALU result as the byte address and the rs2 value as store data.
- Performs RV32I byte, halfword and word accesses with sign or zero extension.
- Returns load data or a store acknowledge over a valid/ready handshake, so the core stalls while an access is in flight.

Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded by the RAM; memory size is 2**ADDR_WIDTH bytes, organised as 2**(ADDR_WIDTH-2) 32-bit words.
- RESET_CLEARS_MEM, 0, when 1, reset zeroes every RAM word (simulation/FPGA only); when 0, RAM contents are untouched by reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes are illegal.
- addr  in  32  byte address (ALU output).
- wdata  in  32  store data, right-aligned (rs2).
- rsp_valid  out  1  one-cycle pulse: response ready.
- rdata  out  32  formatted load data; 0 for stores and errors.
- err  out  1  valid only with rsp_valid; 1 = misaligned, illegal funct3, or out of range.

Behaviour:
- Reset: state=IDLE; req_ready=1, rsp_valid=0, rdata=0, err=0. An in-flight access is abandoned and no response is issued. A store whose accept edge coincides with rst high is not written.
- States: IDLE, LOAD, RESP.
- IDLE:
  - req_ready=1; accept on req_valid&&req_ready.
  - Error check on accept: half access with addr[0]!=0, word access with addr[1:0]!=0, illegal funct3, or illegal store code (funct3 1xx with req_write=1).
  - Error: no RAM access; go to RESP with err=1, rdata=0.
  - Store OK: byte lanes written at the accept edge. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all 4 lanes, little-endian. Go to RESP with err=0, rdata=0.
  - Load OK: RAM word at addr[ADDR_WIDTH-1:2] is read synchronously; go to LOAD.
- LOAD:
  - req_ready=0.
  - Select the byte or half by the latched addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Register the result into rdata; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; req_ready=0; go to IDLE.
  - rdata and err hold until the next response.
- Latency from the accept edge to rsp_valid high: store/error 1 cycle, load 2 cycles. Back-to-back throughput: one request per 2 cycles (store) or 3 cycles (load).
- Request fields are latched at accept; input changes while req_ready=0 are ignored.
- A load after a store to the same word returns the new data, since the write completes before the next accept.
- Address wrap: with the range check disabled, addr bits above ADDR_WIDTH-1 are ignored, so the RAM aliases.

Optional Feature:
- Macro: LSU_RANGE_CHECK_EN.
- Defined: a request with any addr[31:ADDR_WIDTH] bit set is an error. No RAM access; response after 1 cycle with err=1, rdata=0.
- Undefined: upper bits are ignored (aliasing); err comes only from misalignment or illegal funct3.

Test Plan:
- Reset, then SW addr=0x10 wdata=0x8081_7F01; LW 0x10 -> store rsp_valid 1 cycle after accept, err=0; load rsp_valid 2 cycles after accept with rdata=0x8081_7F01.
- Sub-word loads from that word:
  - LB 0x10 -> 0x0000_0001; LB 0x11 -> 0x0000_007F.
  - LB 0x12 -> 0xFFFF_FF81; LBU 0x12 -> 0x0000_0081.
  - LH 0x12 -> 0xFFFF_8081; LHU 0x12 -> 0x0000_8081.
- SB 0x13 wdata=0xAA, then SH 0x10 wdata=0x1234, then LW 0x10 -> 0xAA81_1234.
- Errors: LW 0x12 -> err=1, rdata=0, response 1 cycle after accept. SH 0x11 -> err=1 and memory unchanged (a following LW 0x10 returns its prior value). funct3=011 -> err=1.
- Handshake: hold req_valid high with a load; req_ready=0 in LOAD and RESP. Change addr mid-access -> the response reflects the original addr; the next accept happens in the cycle after RESP.
- rst during LOAD -> no rsp_valid, req_ready=1 the cycle after rst. With LSU_RANGE_CHECK_EN, LW 0x0000_1000 (ADDR_WIDTH=12) -> err=1. Without it, the same LW returns the word at 0x000.
